// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 datapath types and defaults
package lc3_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic [15:0] PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_F1   = 2'd1,
        ST_F2   = 2'd2,
        ST_F3   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_wait_counter.sv
// rtl/fetch_wait_counter.sv - saturating F2 wait-state counter with terminal flag
module fetch_wait_counter #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX);
    localparam logic [W-1:0] LAST  = W'(MAX - 1);

    logic [W-1:0] count_q;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != LIMIT)) begin
            count_q <= count_q + W'(1);
        end
    end

    // Flags the cycle whose increment would reach the limit, so the abort
    // lands on the closing edge of the MAX-th wait cycle.
    assign tc = (count_q >= LAST);

endmodule

// File: rtl/lc3_fetch_unit.sv
// rtl/lc3_fetch_unit.sv - LC-3 instruction fetch sequencer (MAR/MDR/IR, PC increment)
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_d,
    output logic              pc_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              busy,
    output logic              mem_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] ir_q;
    logic              ir_valid_q;
    logic              mem_err_q;

    logic mar_en, mdr_en, err_set;
    logic cnt_clr, cnt_inc, cnt_tc;

    fetch_wait_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        mar_en  = 1'b0;
        mdr_en  = 1'b0;
        err_set = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mar_en  = 1'b1;
                    state_d = ST_F1;
                end
            end
            ST_F1: begin
                cnt_clr = 1'b1;
                state_d = ST_F2;
            end
            ST_F2: begin
                if (mem_ready) begin
                    mdr_en  = 1'b1;
                    state_d = ST_F3;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_tc) begin
                        err_set = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_F3: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Falling edge matches the PC register so pc_en/pc_d are stable at its capture edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mar_q      <= ADDR_W'(PC_RESET);
            mdr_q      <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_valid_q <= (state_q == ST_F3);
            if (mar_en) begin
                mar_q <= pc_q;
            end
            if (mdr_en) begin
                mdr_q <= mem_rdata;
            end
            if (state_q == ST_F3) begin
                ir_q <= mdr_q;
            end
            if (err_set) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign pc_d     = mar_q + ADDR_W'(1);
    assign pc_en    = (state_q == ST_F1);
    assign mem_rd   = (state_q == ST_F2);
    assign mem_addr = mar_q;
    assign busy     = (state_q != ST_IDLE);
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// tb/tb_lc3_fetch_unit.sv - directed self-checking bench for lc3_fetch_unit
module tb_lc3_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic        pc_en;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    lc3_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pc_q      (pc_q),
        .pc_d      (pc_d),
        .pc_en     (pc_en),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // DUT updates on negedge; observe and drive just after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ir"},       32'(ir),       32'h0000);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 32'h0);
        chk({tag, "_mem_err"},  32'(mem_err),  32'h0);
        chk({tag, "_busy"},     32'(busy),     32'h0);
        chk({tag, "_pc_en"},    32'(pc_en),    32'h0);
        chk({tag, "_mem_rd"},   32'(mem_rd),   32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0000);
        chk({tag, "_pc_d"},     32'(pc_d),     32'h0001);
    endtask

    int pc_en_cnt;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pc_q      = 16'h0000;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;

        // Zero-wait fetch from 0x3000
        step();
        pc_q  = 16'h3000;
        start = 1'b1;
        step();                                   // cycle 1: F1
        chk("f1_pc_en",  32'(pc_en),  32'h1);
        chk("f1_pc_d",   32'(pc_d),   32'h3001);
        chk("f1_mem_rd", 32'(mem_rd), 32'h0);
        chk("f1_busy",   32'(busy),   32'h1);
        start = 1'b0;
        step();                                   // cycle 2: F2
        chk("f2_mem_rd",   32'(mem_rd),   32'h1);
        chk("f2_mem_addr", 32'(mem_addr), 32'h3000);
        chk("f2_pc_en",    32'(pc_en),    32'h0);
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        step();                                   // cycle 3: F3
        chk("f3_ir_valid", 32'(ir_valid), 32'h0);
        chk("f3_mem_rd",   32'(mem_rd),   32'h0);
        chk("f3_busy",     32'(busy),     32'h1);
        mem_ready = 1'b0;
        mem_rdata = 16'hDEAD;
        step();                                   // cycle 4: ir_valid
        chk("zw_ir",       32'(ir),       32'h1234);
        chk("zw_ir_valid", 32'(ir_valid), 32'h1);
        chk("zw_busy",     32'(busy),     32'h0);

        // Back-to-back start in the ir_valid cycle, PC wrap, 3 wait states
        pc_q  = 16'hFFFF;
        start = 1'b1;
        step();                                   // F1
        chk("b2b_pc_en",    32'(pc_en),    32'h1);
        chk("wrap_pc_d",    32'(pc_d),     32'h0000);
        chk("b2b_ir_valid", 32'(ir_valid), 32'h0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin         // F2 wait cycles, with ignored start pulses
            step();
            chk("ws_mem_rd",   32'(mem_rd),   32'h1);
            chk("ws_mem_addr", 32'(mem_addr), 32'hFFFF);
            start = (i < 2);
        end
        step();                                   // 4th F2 cycle
        chk("ws_mem_rd_last", 32'(mem_rd), 32'h1);
        start     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hABCD;
        step();                                   // F3
        chk("ws_f3_ir_valid", 32'(ir_valid), 32'h0);
        mem_ready = 1'b0;
        step();
        chk("ws_ir",       32'(ir),       32'hABCD);
        chk("ws_ir_valid", 32'(ir_valid), 32'h1);
        chk("ws_mem_err",  32'(mem_err),  32'h0);
        step();
        chk("ws_ir_valid_clr", 32'(ir_valid), 32'h0);
        chk("ws_no_queue",     32'(busy),     32'h0);

        // Timeout: mem_ready never asserted
        pc_q  = 16'h4000;
        start = 1'b1;
        step();                                   // F1
        chk("to_pc_d", 32'(pc_d), 32'h4001);
        pc_en_cnt = int'(pc_en);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_mem_rd",   32'(mem_rd),   32'h1);
            chk("to_ir_valid", 32'(ir_valid), 32'h0);
            chk("to_err_pend", 32'(mem_err),  32'h0);
            pc_en_cnt += int'(pc_en);
        end
        step();
        chk("to_mem_err",  32'(mem_err),  32'h1);
        chk("to_busy",     32'(busy),     32'h0);
        chk("to_ir",       32'(ir),       32'hABCD);
        chk("to_ir_valid", 32'(ir_valid), 32'h0);
        pc_en_cnt += int'(pc_en);
        step();
        pc_en_cnt += int'(pc_en);
        chk("to_pc_en_once",  32'(pc_en_cnt), 32'd1);
        chk("to_err_sticky",  32'(mem_err),   32'h1);

        // Reset in the middle of F2
        pc_q  = 16'h5000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();                                   // F2
        chk("mr_mem_rd", 32'(mem_rd), 32'h1);
        reset = 1'b1;
        #1;
        chk_reset_vals("mr");
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        reset = 1'b0;
        step();
        chk("mr_late_busy", 32'(busy),     32'h0);
        chk("mr_late_ir",   32'(ir),       32'h0000);
        chk("mr_late_iv",   32'(ir_valid), 32'h0);
        mem_ready = 1'b0;

        // Normal fetch after reset
        pc_q  = 16'h6000;
        start = 1'b1;
        step();
        chk("pr_pc_d", 32'(pc_d), 32'h6001);
        start = 1'b0;
        step();
        chk("pr_mem_addr", 32'(mem_addr), 32'h6000);
        mem_ready = 1'b1;
        mem_rdata = 16'h7777;
        step();
        mem_ready = 1'b0;
        step();
        chk("pr_ir",       32'(ir),       32'h7777);
        chk("pr_ir_valid", 32'(ir_valid), 32'h1);
        chk("pr_mem_err",  32'(mem_err),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_unit.md
# lc3_fetch_unit

Instruction-fetch sequencer for the LC-3 datapath. It reads the current PC, issues a single-word memory read at that address, and writes back PC+1 to the PC register. It then latches the returned word into the instruction register (IR) and hands it to decode with a one-cycle valid pulse. It sits between the control unit (start request), the 16-bit PC register (PC read, PC load-enable), and the memory interface (read request/ready).

## Interface
- `ADDR_W`, default 16: address width; equals the PC width.
- `DATA_W`, default 16: memory word and IR width.
- `MAX_WAIT`, default 15: maximum F2 cycles spent waiting for `mem_ready` before a fetch is aborted.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock. All state updates on the falling edge, the same edge as the PC register.
- `reset` in 1: asynchronous, active-high; returns all state to reset values immediately.
- `start` in 1: fetch request from the control unit; sampled in IDLE only.
- `pc_q` in ADDR_W: current PC register output.
- `pc_d` out ADDR_W: next PC value, equal to MAR+1.
- `pc_en` out 1: PC register load-enable.
- `mem_addr` out ADDR_W: read address; driven from MAR.
- `mem_rd` out 1: memory read request.
- `mem_rdata` in DATA_W: memory read data.
- `mem_ready` in 1: read data valid this cycle.
- `ir` out DATA_W: instruction register.
- `ir_valid` out 1: one-cycle pulse; a new instruction is in `ir`.
- `busy` out 1: high in every state except IDLE.
- `mem_err` out 1: sticky flag; set by a fetch timeout.

## Operation
- Internal registers: MAR, MDR, IR, a wait counter, and the state register (IDLE, F1, F2, F3).
- **IDLE**:
  - `start`=1 at an edge: MAR←`pc_q`, next state F1.
  - `start`=0: stay in IDLE.
- **F1**: `pc_en`=1 and `pc_d`=MAR+1, modulo 2^ADDR_W, so 0xFFFF→0x0000. Wait counter←0. Next state F2.
- **F2**: `mem_rd`=1 and `mem_addr`=MAR.
  - `mem_ready`=1: MDR←`mem_rdata`, next state F3.
  - Otherwise the wait counter increments. If the counter equals MAX_WAIT with `mem_ready`=0: `mem_err`←1, next state IDLE, IR unchanged, no `ir_valid`.
- **F3**: IR←MDR and `ir_valid`←1 at the closing edge. Next state IDLE.
- `ir_valid` is a register. It clears at the edge following the edge that set it.
- `start` asserted in any non-IDLE state is ignored and not queued.
- `mem_err` clears only on `reset`.
- `mem_ready` asserted outside F2 is ignored.
- `pc_en` is high only in F1; exactly one PC increment occurs per accepted `start`, including fetches that later abort.

## Timing
- Reset values:
  - state IDLE
  - MAR, MDR, IR = 0x0000
  - `ir_valid`=0, `mem_err`=0, `busy`=0
  - `pc_en`=0, `mem_rd`=0, `mem_addr`=0x0000, `pc_d`=0x0001
- `pc_en`, `mem_rd`, `busy`, `mem_addr` and `pc_d` are decoded from the state and registers only; they never depend combinationally on `start` or `mem_ready`.
- Latency with zero wait states: edge 0 accepts `start`; cycle 1 is F1; cycle 2 is F2 with `mem_ready`=1; cycle 3 is F3; `ir_valid`=1 in cycle 4.
- Each wait state adds one cycle.
- `start` may be asserted in the `ir_valid` cycle and is accepted, giving back-to-back fetches every 4 cycles.
- Reset mid-operation (any state): outputs go to reset values asynchronously, with no glitch on `pc_en` beyond the reset assertion. An in-flight read is abandoned, and `mem_rdata` arriving after reset is ignored.

## Structure
- The shared LC-3 package holds the state encoding enum (IDLE=0, F1=1, F2=2, F3=3), `ADDR_W`/`DATA_W` defaults, and the PC reset constant.
- One natural sub-module, `fetch_wait_counter`: a saturating counter with clear and a terminal-count flag, width clog2(MAX_WAIT+1).
- MAR, MDR and IR are plain enabled registers inline.

## Test plan
- Reset, then `pc_q`=0x3000, `start` pulse, memory returns 0x1234 in the first F2 cycle:
  - `mem_addr`=0x3000 during F2, `pc_d`=0x3001 with `pc_en` high for exactly one cycle.
  - `ir`=0x1234 and `ir_valid` high for one cycle, 4 cycles after `start`.
- `mem_ready` delayed 3 cycles: `mem_rd` held for 4 cycles, `ir_valid` arrives 3 cycles later than the zero-wait case, and `mem_err`=0.
- `mem_ready` never asserted: after 15 F2 cycles `mem_err`=1, back to IDLE, `ir` unchanged, no `ir_valid`, PC incremented exactly once.
- `pc_q`=0xFFFF fetch → `pc_d`=0x0000. `start` re-asserted in the `ir_valid` cycle → second fetch begins immediately. `start` pulses during F2 are ignored.
- `reset` asserted mid-F2 → all outputs at reset values before the next clock edge. A late `mem_ready` is ignored, and the next `start` fetches normally.
